demux_1to4_stream: RTL and testbench
====================================

Name: demux_1to4_stream

Overview:
- Stream-level 1-to-4 demultiplexer with valid/ready handshakes on the input and on each of the four outputs.
- A 2-entry FIFO sits in front of the routing logic. Each beat is steered to one output channel, chosen either by the beat's own destination field or by an internal round-robin pointer.
- Each channel has a saturating beat counter for debug and performance readout.
- Sits between a single producer and four consumer lanes. Its zeroing convention on unselected outputs matches the combinational 1-to-4 demux.

Parameters:
- WIDTH, 8, data width of each beat.
- RR_MODE, 0, 0 = route by in_dest; 1 = round-robin routing, in_dest ignored.
- CNT_W, 16, width of each per-channel beat counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input beat data.
- in_dest  input  2  destination channel 0..3; used only when RR_MODE=0.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- out0_data, out1_data, out2_data, out3_data  output  WIDTH each  channel data; zero when the channel is not selected.
- out0_valid, out1_valid, out2_valid, out3_valid  output  1 each  channel valid.
- out0_ready, out1_ready, out2_ready, out3_ready  input  1 each  channel ready.
- cnt0, cnt1, cnt2, cnt3  output  CNT_W each  beats delivered per channel, saturating.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - FIFO empty (count=0), rd/wr pointers = 0, rr pointer = 0.
  - All outN_valid = 0, all outN_data = 0, all cntN = 0.
  - in_ready = 1 in the first cycle after rst deasserts.
- FIFO:
  - Depth 2; each entry holds {data, dest}.
  - in_ready = (count < 2). It is registered-state-only, with no combinational path from outN_ready.
- Push: in_valid & in_ready at a rising edge.
  - Stored dest = in_dest if RR_MODE=0, else the rr pointer.
  - The rr pointer increments on every push and wraps 3 -> 0.
- Head presentation:
  - When count > 0, the head entry drives out{dest}_valid = 1 and out{dest}_data = head data.
  - The other three channels have valid = 0 and data = 0.
  - When count = 0, all valids and all data are 0.
- Pop: out{dest}_valid & out{dest}_ready at a rising edge.
  - Ready on a non-selected channel has no effect.
- Latency: a beat pushed at edge N is visible on its output after edge N. That is one cycle minimum when the FIFO was empty, i.e. a zero-cycle fall-through is not allowed.
- Simultaneous push and pop:
  - Count unchanged; both pointers advance.
  - Sustained throughput is 1 beat/cycle when the selected consumer is always ready.
- Full (count=2):
  - in_ready = 0 and in_valid is ignored.
  - A pop in this cycle frees a slot, which is visible as in_ready = 1 the next cycle.
- Empty: no outN_valid is asserted; outN_ready is ignored.
- Stability: while outN_valid = 1 and outN_ready = 0, data and dest are held stable every cycle.
- Counters:
  - cntN increments by 1 on each pop to channel N.
  - Saturates at all-ones and never wraps.
- Reset mid-operation:
  - Stored beats are discarded.
  - Valids drop the cycle after the rst edge.
  - Counters clear and the rr pointer returns to 0.
- in_dest is treated as an unsigned 2-bit value; all four values are legal.

Test Plan:
- Dest routing (RR_MODE=0, WIDTH=8, all outN_ready=1): push 0xA1/dest2, 0xB2/dest0, 0xC3/dest3 back-to-back.
  - -> out2 gets 0xA1, out0 gets 0xB2, out3 gets 0xC3, each 1 cycle after its push, one per cycle.
  - -> cnt2 = cnt0 = cnt3 = 1, cnt1 = 0.
  - -> Unselected data buses read 0.
- Backpressure/full: out1_ready=0, push 0x11, 0x22, 0x33, all dest1.
  - -> First two accepted; in_ready=0 and 0x33 stalls; out1 holds 0x11 stable.
  - -> Raise out1_ready: 0x11 then 0x22 are delivered, 0x33 is accepted the cycle after in_ready rises, and order is preserved.
- Round-robin (RR_MODE=1): push 6 beats 0x00..0x05 with in_dest=0 throughout.
  - -> Delivered to channels 0,1,2,3,0,1.
  - -> cnt0 = 2, cnt1 = 2, cnt2 = 1, cnt3 = 1.
- Wrong-channel ready: head dest3; out3_ready=0 while out0/1/2_ready=1 for 5 cycles.
  - -> No pop and count unchanged.
  - -> Raise out3_ready -> single pop.
- Counter saturation (CNT_W=3): deliver 10 beats to channel 0.
  - -> cnt0 sequence ends at 7 and stays at 7.
- Reset mid-stream: FIFO holding 2 beats, assert rst for 1 cycle.
  - -> All valids 0, counters 0, in_ready=1 next cycle.
  - -> The next push (RR_MODE=1) goes to channel 0.

Source files
------------

// File: rtl/demux_1to4_stream.sv
// Stream 1-to-4 demultiplexer: a 2-entry FIFO feeds four valid/ready output lanes,
// steered by each beat's dest field or a round-robin pointer, with per-lane beat counters.
module demux_1to4_stream #(
    parameter int WIDTH   = 8,
    parameter int RR_MODE = 0,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [WIDTH-1:0] out3_data,
    output logic             out0_valid,
    output logic             out1_valid,
    output logic             out2_valid,
    output logic             out3_valid,
    input  logic             out0_ready,
    input  logic             out1_ready,
    input  logic             out2_ready,
    input  logic             out3_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    // Handshake: a beat transfers on a rising edge where valid and ready are both high;
    // valid never depends on ready, and in_ready depends only on registered FIFO state.
    logic [WIDTH-1:0] mem_data [2];
    logic [1:0]       mem_dest [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] cnt_q [4];

    logic             push;
    logic             pop;
    logic [1:0]       push_dest;
    logic [WIDTH-1:0] head_data;
    logic [1:0]       head_dest;
    logic [3:0]       valid_vec;
    logic [3:0]       ready_vec;

    assign in_ready  = (count < 2'd2);
    assign push      = in_valid & in_ready;
    assign push_dest = (RR_MODE != 0) ? rr_ptr : in_dest;
    assign head_data = mem_data[rd_ptr];
    assign head_dest = mem_dest[rd_ptr];
    assign ready_vec = {out3_ready, out2_ready, out1_ready, out0_ready};

    always_comb begin
        valid_vec = 4'b0000;
        if (count != 2'd0) begin
            valid_vec[head_dest] = 1'b1;
        end
    end

    // Only the selected lane's ready can complete a pop.
    assign pop = |(valid_vec & ready_vec);

    assign out0_valid = valid_vec[0];
    assign out1_valid = valid_vec[1];
    assign out2_valid = valid_vec[2];
    assign out3_valid = valid_vec[3];
    assign out0_data  = valid_vec[0] ? head_data : '0;
    assign out1_data  = valid_vec[1] ? head_data : '0;
    assign out2_data  = valid_vec[2] ? head_data : '0;
    assign out3_data  = valid_vec[3] ? head_data : '0;

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_dest[wr_ptr] <= push_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            rr_ptr <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
                rr_ptr <= rr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            // Counters stick at all-ones rather than wrapping.
            for (int i = 0; i < 4; i++) begin
                if (pop && (head_dest == 2'(i)) && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Directed bench: dut_a routes by dest with 3-bit counters, dut_b routes round-robin.
module tb_demux_1to4_stream;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic       in_valid_a;
    logic       in_valid_b;
    logic [3:0] rdy;

    logic       a_in_ready;
    logic [7:0] a_data [4];
    logic       a_valid [4];
    logic [2:0] a_cnt [4];

    logic        b_in_ready;
    logic [7:0]  b_data [4];
    logic        b_valid [4];
    logic [15:0] b_cnt [4];

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    demux_1to4_stream #(.WIDTH(8), .RR_MODE(0), .CNT_W(3)) dut_a (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid_a), .in_ready(a_in_ready),
        .out0_data(a_data[0]), .out1_data(a_data[1]), .out2_data(a_data[2]), .out3_data(a_data[3]),
        .out0_valid(a_valid[0]), .out1_valid(a_valid[1]), .out2_valid(a_valid[2]), .out3_valid(a_valid[3]),
        .out0_ready(rdy[0]), .out1_ready(rdy[1]), .out2_ready(rdy[2]), .out3_ready(rdy[3]),
        .cnt0(a_cnt[0]), .cnt1(a_cnt[1]), .cnt2(a_cnt[2]), .cnt3(a_cnt[3])
    );

    demux_1to4_stream #(.WIDTH(8), .RR_MODE(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid_b), .in_ready(b_in_ready),
        .out0_data(b_data[0]), .out1_data(b_data[1]), .out2_data(b_data[2]), .out3_data(b_data[3]),
        .out0_valid(b_valid[0]), .out1_valid(b_valid[1]), .out2_valid(b_valid[2]), .out3_valid(b_valid[3]),
        .out0_ready(rdy[0]), .out1_ready(rdy[1]), .out2_ready(rdy[2]), .out3_ready(rdy[3]),
        .cnt0(b_cnt[0]), .cnt1(b_cnt[1]), .cnt2(b_cnt[2]), .cnt3(b_cnt[3])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Checks the full output picture of dut_a: only channel ch valid with data d (ch=4 -> none).
    task automatic check_a_lanes(input string name, input int ch, input logic [7:0] d);
        for (int i = 0; i < 4; i++) begin
            logic       ev;
            logic [7:0] ed;
            ev = (i == ch);
            ed = (i == ch) ? d : 8'h00;
            checks++;
            if (a_valid[i] !== ev || a_data[i] !== ed) begin
                errors++;
                $display("FAIL %s lane%0d: got valid=%b data=%02h, expected valid=%b data=%02h",
                         name, i, a_valid[i], a_data[i], ev, ed);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0;
        in_data = 8'h00; in_dest = 2'd0; rdy = 4'b0000;
        tick(); tick();
        rst = 1'b0;
        check_a_lanes("reset_a", 4, 8'h00);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_cnt[i] !== 3'd0 || b_cnt[i] !== 16'd0 || b_valid[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_cnt%0d: got a=%0d b=%0d bvalid=%b, expected 0 0 0",
                         i, a_cnt[i], b_cnt[i], b_valid[i]);
            end
        end
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got a=%b b=%b, expected 1 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_dest_routing();
        logic [7:0] vd [3];
        logic [1:0] vt [3];
        vd[0] = 8'hA1; vt[0] = 2'd2;
        vd[1] = 8'hB2; vt[1] = 2'd0;
        vd[2] = 8'hC3; vt[2] = 2'd3;
        rdy = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            in_valid_a = 1'b1; in_data = vd[k]; in_dest = vt[k];
            tick();
            check_a_lanes("route", int'(vt[k]), vd[k]);
        end
        in_valid_a = 1'b0;
        tick();
        check_a_lanes("route_drain", 4, 8'h00);
        checks++;
        if (a_cnt[0] !== 3'd1 || a_cnt[1] !== 3'd0 || a_cnt[2] !== 3'd1 || a_cnt[3] !== 3'd1) begin
            errors++;
            $display("FAIL route_cnt: got %0d %0d %0d %0d, expected 1 0 1 1",
                     a_cnt[0], a_cnt[1], a_cnt[2], a_cnt[3]);
        end
    endtask

    task automatic test_backpressure();
        rdy = 4'b1101;
        in_dest = 2'd1;
        in_valid_a = 1'b1; in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        in_data = 8'h33;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (a_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_full: got in_ready=%b, expected 0", a_in_ready);
            end
            check_a_lanes("bp_hold", 1, 8'h11);
            tick();
        end
        rdy = 4'b1111;
        tick();
        check_a_lanes("bp_second", 1, 8'h22);
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_slot_free: got in_ready=%b, expected 1", a_in_ready);
        end
        tick();
        in_valid_a = 1'b0;
        check_a_lanes("bp_third", 1, 8'h33);
        tick();
        check_a_lanes("bp_drain", 4, 8'h00);
        checks++;
        if (a_cnt[1] !== 3'd3) begin
            errors++;
            $display("FAIL bp_cnt1: got %0d, expected 3", a_cnt[1]);
        end
    endtask

    task automatic test_wrong_channel();
        rdy = 4'b0111;
        in_valid_a = 1'b1; in_data = 8'h44; in_dest = 2'd3;
        tick();
        in_valid_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_a_lanes("wrong_ch_hold", 3, 8'h44);
            checks++;
            if (a_cnt[3] !== 3'd1 || a_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL wrong_ch_nopop: got cnt3=%0d in_ready=%b, expected 1 1",
                         a_cnt[3], a_in_ready);
            end
            tick();
        end
        rdy = 4'b1111;
        tick();
        check_a_lanes("wrong_ch_pop", 4, 8'h00);
        checks++;
        if (a_cnt[3] !== 3'd2) begin
            errors++;
            $display("FAIL wrong_ch_cnt3: got %0d, expected 2", a_cnt[3]);
        end
    endtask

    task automatic test_counter_saturation();
        int exp_cnt;
        do_reset();
        rdy = 4'b1111;
        in_dest = 2'd0;
        for (int k = 1; k <= 11; k++) begin
            in_valid_a = (k <= 10);
            in_data = 8'(k);
            tick();
            exp_cnt = (k - 1 > 7) ? 7 : k - 1;
            checks++;
            if (a_cnt[0] !== 3'(exp_cnt)) begin
                errors++;
                $display("FAIL sat_cnt0 step%0d: got %0d, expected %0d", k, a_cnt[0], exp_cnt);
            end
        end
        in_valid_a = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_ch [6];
        logic [7:0] exp_d;
        exp_ch = '{0, 1, 2, 3, 0, 1};
        do_reset();
        rdy = 4'b1111;
        in_dest = 2'd0;
        for (int k = 0; k < 6; k++) begin
            in_valid_b = 1'b1; in_data = 8'(k);
            exp_q.push_back(8'(k));
            tick();
            exp_d = exp_q.pop_front();
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (b_valid[i] !== (i == exp_ch[k]) || b_data[i] !== ((i == exp_ch[k]) ? exp_d : 8'h00)) begin
                    errors++;
                    $display("FAIL rr beat%0d lane%0d: got valid=%b data=%02h, expected lane %0d data %02h",
                             k, i, b_valid[i], b_data[i], exp_ch[k], exp_d);
                end
            end
        end
        in_valid_b = 1'b0;
        tick();
        checks++;
        if (b_cnt[0] !== 16'd2 || b_cnt[1] !== 16'd2 || b_cnt[2] !== 16'd1 || b_cnt[3] !== 16'd1) begin
            errors++;
            $display("FAIL rr_cnt: got %0d %0d %0d %0d, expected 2 2 1 1",
                     b_cnt[0], b_cnt[1], b_cnt[2], b_cnt[3]);
        end
    endtask

    task automatic test_reset_midstream();
        rdy = 4'b0000;
        in_valid_b = 1'b1; in_data = 8'h55;
        tick();
        in_data = 8'h66;
        tick();
        in_valid_b = 1'b0;
        checks++;
        if (b_in_ready !== 1'b0 || b_valid[2] !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: got in_ready=%b valid2=%b, expected 0 1", b_in_ready, b_valid[2]);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b_valid[i] !== 1'b0 || b_data[i] !== 8'h00 || b_cnt[i] !== 16'd0) begin
                errors++;
                $display("FAIL mid_reset lane%0d: got valid=%b data=%02h cnt=%0d, expected 0 00 0",
                         i, b_valid[i], b_data[i], b_cnt[i]);
            end
        end
        checks++;
        if (b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_ready: got %b, expected 1", b_in_ready);
        end
        rdy = 4'b1111;
        in_valid_b = 1'b1; in_data = 8'h77; in_dest = 2'd3;
        tick();
        in_valid_b = 1'b0;
        checks++;
        if (b_valid[0] !== 1'b1 || b_data[0] !== 8'h77 || b_valid[3] !== 1'b0) begin
            errors++;
            $display("FAIL mid_rr_restart: got valid0=%b data0=%02h valid3=%b, expected 1 77 0",
                     b_valid[0], b_data[0], b_valid[3]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_dest_routing();
        test_backpressure();
        test_wrong_channel();
        test_counter_saturation();
        test_round_robin();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
